ps2_scan_rx: RTL and testbench
==============================

# ps2_scan_rx

PS/2 device-to-host receiver feeding the keyboard matrix decoder. Synchronises and de-glitches the raw PS/2 clock/data lines, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop), and buffers valid scan codes in a small FIFO. Presents them through a ready/read handshake in which the byte appears on `rx_scan_code` one cycle after the read pulse. Transmit (host-to-device) is out of scope.

## Interface
- `FILTER_LEN`, 8: consecutive identical samples required before the filtered PS/2 clock changes.
- `TIMEOUT_CYC`, 100000: idle cycles between falling edges mid-frame before abort (2 ms at 50 MHz).
- `FIFO_DEPTH`, 4: scan-code buffer entries; power of two, ≥2.

- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk_i` in 1: raw PS/2 clock, asynchronous.
- `ps2_data_i` in 1: raw PS/2 data, asynchronous.
- `rx_scan_code` out 8: last byte popped; stable until the next accepted read.
- `rx_data_ready` out 1: FIFO not empty.
- `rx_read` in 1: pop request, one cycle; ignored when `rx_data_ready`=0.
- `rx_parity_err` out 1: one-cycle pulse, bad parity frame dropped.
- `rx_frame_err` out 1: one-cycle pulse, stop bit 0 or timeout, frame dropped.
- `rx_overflow` out 1: sticky, byte dropped because FIFO full.

## Operation
- Input path: 2-flop synchronisers on both lines, then a counter filter on the clock (data not filtered). Filtered clock resets to 1. A falling edge is a 1→0 transition of the filtered clock. Synchronised data is sampled in that cycle.
- FSM states:
  - IDLE: on a falling edge with data=0 (start bit), go to SHIFT, bit count=0. If data=1, stay in IDLE with no error.
  - SHIFT: each falling edge shifts data into bit[count], LSB first. After 8 bits go to PARITY.
  - PARITY: latch the parity bit on the edge, go to STOP.
  - STOP: on the edge, if stop=1 and the popcount of data+parity is odd, push the byte. If stop=0, pulse frame_err. If parity is bad (stop=1), pulse parity_err. In all cases return to IDLE.
- Timeout: a counter clears on every falling edge and in IDLE. In any state other than IDLE, reaching `TIMEOUT_CYC` forces IDLE, pulses frame_err and drops partial data.
- FIFO:
  - Push when full: the byte is dropped and `rx_overflow` is set. Existing entries are kept.
  - Simultaneous push and pop when full: pop first, push accepted, no overflow.
  - `rx_overflow` clears on the next accepted read or on reset.
- Read: `rx_read`=1 with ready=1 pops the head into the `rx_scan_code` register at that clock edge. FIFO count decrements in the same edge.
- Reset (including mid-frame): FSM→IDLE, FIFO empty, filter/synchronisers →1, counters 0. All outputs 0: `rx_scan_code`=8'h00, ready=0, errors=0, overflow=0.

## Timing
- Filtered-edge latency after a raw clock fall: 2 (sync) + `FILTER_LEN` cycles.
- Push occurs on the edge ending the cycle in which the stop bit is sampled. `rx_data_ready` is high from the next cycle.
- Read in cycle N:
  - `rx_scan_code` holds the new byte from N+1.
  - `rx_data_ready` falls in N+1 if the FIFO became empty.
  - A consumer may sample `rx_scan_code` at N+1 or later.
- Error pulses are exactly one cycle, in the cycle after the stop-bit sample or timeout.
- Back-to-back frames need no gap: IDLE accepts a start edge immediately after STOP.

## Structure
- Shared package `ps2_pkg`:
  - FSM state enum (IDLE, SHIFT, PARITY, STOP).
  - Frame-length constant 11.
  - Scan-code prefix constants 8'hE0 and 8'hF0, for use by consumers.
- Sub-module `ps2_scan_fifo`: synchronous FIFO parameterised on depth. Pointers carry an extra wrap bit. Pop-before-push ordering when full.
- Top level holds the synchronisers, filter, FSM, timeout counter and output register.

## Test plan
- Single frame 0x1C (parity 0), 60 µs bit period, no read pending → one push, ready=1; read → `rx_scan_code`=0x1C next cycle, ready=0.
- Frame 0x1C with parity 1 → `rx_parity_err` one-cycle pulse, ready stays 0. A following good 0x5A frame is received correctly.
- Sequence F0, 1C with no read, then two reads spaced 3 cycles apart → `rx_scan_code`=0xF0, then 0x1C, then ready=0.
- Five frames 0x01..0x05 with no reads → `rx_overflow`=1; reads return 0x01..0x04; overflow clears on the first read.
- Raw clock glitch of `FILTER_LEN`-2 cycles in IDLE → no state change. Abort after 5 data bits, then wait `TIMEOUT_CYC` → frame_err pulse and IDLE. Next frame 0x29 is received intact.
- Reset asserted mid-frame (bit 4) and after 2 buffered bytes → all outputs 0, FIFO empty. Next full frame 0x66 is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 receiver types and constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} rx_state_t;
  localparam int FRAME_LEN = 11;
  localparam logic [7:0] SC_EXTEND = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
endpackage

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: scan-code FIFO with wrap-bit pointers, pop-before-push when full
module ps2_scan_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 device-to-host receiver with filter, deframer and scan-code FIFO
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_scan_code,
  output logic       rx_data_ready,
  input  logic       rx_read,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_overflow
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [1:0] sync_clk, sync_dat;
  logic [FW-1:0] flt_cnt;
  logic flt_clk, flt_clk_d, fall, dat, flt_hit;
  rx_state_t state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, head;
  logic par, par_n, push, perr_n, ferr_n, timeout, pop, empty, full;
  logic [TW-1:0] tmo;
  assign dat = sync_dat[1];
  assign fall = flt_clk_d & ~flt_clk;
  assign flt_hit = flt_cnt == FW'(FILTER_LEN - 1);
  assign timeout = state != IDLE && tmo == TW'(TIMEOUT_CYC - 1);
  assign pop = rx_read & ~empty;
  assign rx_data_ready = ~empty;
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    par_n = par;
    push = 1'b0;
    perr_n = 1'b0;
    ferr_n = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      ferr_n = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          state_n = dat ? IDLE : SHIFT;
          bit_cnt_n = 3'd0;
        end
        SHIFT: begin
          shreg_n = {dat, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'd7 ? PARITY : SHIFT;
        end
        PARITY: begin
          par_n = dat;
          state_n = STOP;
        end
        default: begin
          state_n = IDLE;
          push = dat & ^{shreg, par};
          ferr_n = ~dat;
          perr_n = dat & ~^{shreg, par};
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_clk <= 2'b11;
      sync_dat <= 2'b11;
      flt_cnt <= '0;
      flt_clk <= 1'b1;
      flt_clk_d <= 1'b1;
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tmo <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overflow <= 1'b0;
      rx_scan_code <= '0;
    end else begin
      sync_clk <= {sync_clk[0], ps2_clk_i};
      sync_dat <= {sync_dat[0], ps2_data_i};
      flt_cnt <= (sync_clk[1] == flt_clk || flt_hit) ? '0 : flt_cnt + 1'b1;
      flt_clk <= (sync_clk[1] != flt_clk && flt_hit) ? sync_clk[1] : flt_clk;
      flt_clk_d <= flt_clk;
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      par <= par_n;
      tmo <= (state == IDLE || fall) ? '0 : tmo + 1'b1;
      rx_parity_err <= perr_n;
      rx_frame_err <= ferr_n;
      rx_overflow <= pop ? 1'b0 : (push & full) ? 1'b1 : rx_overflow;
      rx_scan_code <= pop ? head : rx_scan_code;
    end
  end
  ps2_scan_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (shreg),
    .dout (head),
    .empty(empty),
    .full (full)
  );
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: scoreboard bench for the PS/2 scan-code receiver
module tb_ps2_scan_rx;
  localparam int FL = 8;
  localparam int TO = 500;
  localparam int HALF = 40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk_i = 1'b1;
  logic ps2_data_i = 1'b1;
  logic rx_read = 1'b0;
  logic [7:0] rx_scan_code;
  logic rx_data_ready, rx_parity_err, rx_frame_err, rx_overflow;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int err_q[$];
  logic rd_pend = 1'b0;
  logic err_prev = 1'b0;
  always #5 clk = ~clk;
  ps2_scan_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .rx_scan_code (rx_scan_code),
    .rx_data_ready(rx_data_ready),
    .rx_read      (rx_read),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overflow  (rx_overflow)
  );
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    ps2_data_i = b;
    cyc(HALF);
    ps2_clk_i = 1'b0;
    cyc(HALF);
    ps2_clk_i = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ par_flip);
    send_bit(stop);
    ps2_data_i = 1'b1;
    cyc(HALF);
  endtask
  task automatic good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b0, 1'b1);
  endtask
  task automatic do_read;
    rx_read = 1'b1;
    cyc(1);
    rx_read = 1'b0;
  endtask
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) fail("unexpected_read");
      else chk("scan_code", rx_scan_code, exp_q.pop_front());
    end
    rd_pend = rx_read & rx_data_ready & ~reset;
    if (rx_parity_err | rx_frame_err) begin
      chk("err_width", err_prev, 0);
      if (err_q.size() == 0) fail("unexpected_err");
      else chk("err_kind", {rx_parity_err, rx_frame_err}, err_q.pop_front());
    end
    err_prev = rx_parity_err | rx_frame_err;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    cyc(5);
    chk("rst_code", rx_scan_code, 0);
    chk("rst_ready", rx_data_ready, 0);
    chk("rst_ovf", rx_overflow, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_ferr", rx_frame_err, 0);
    reset = 1'b0;
    cyc(5);
    good(8'h1C);
    chk("single_ready", rx_data_ready, 1);
    do_read();
    chk("single_drained", rx_data_ready, 0);
    cyc(3);
    err_q.push_back(2);
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("parity_seen", err_q.size(), 0);
    chk("parity_ready", rx_data_ready, 0);
    good(8'h5A);
    chk("after_parity_ready", rx_data_ready, 1);
    do_read();
    cyc(3);
    good(8'hF0);
    good(8'h1C);
    do_read();
    chk("seq_ready_mid", rx_data_ready, 1);
    cyc(3);
    do_read();
    chk("seq_drained", rx_data_ready, 0);
    for (int i = 1; i <= 4; i++) good(8'(i));
    send_frame(8'h05, 1'b0, 1'b1);
    chk("ovf_set", rx_overflow, 1);
    chk("ovf_ready", rx_data_ready, 1);
    do_read();
    chk("ovf_clear", rx_overflow, 0);
    for (int i = 0; i < 3; i++) do_read();
    chk("ovf_drained", rx_data_ready, 0);
    ps2_data_i = 1'b0;
    cyc(2);
    ps2_clk_i = 1'b0;
    cyc(FL - 2);
    ps2_clk_i = 1'b1;
    cyc(2);
    ps2_data_i = 1'b1;
    cyc(TO + 100);
    chk("glitch_ready", rx_data_ready, 0);
    err_q.push_back(1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ps2_data_i = 1'b1;
    cyc(TO + 100);
    chk("timeout_seen", err_q.size(), 0);
    chk("timeout_ready", rx_data_ready, 0);
    good(8'h29);
    do_read();
    cyc(3);
    err_q.push_back(1);
    send_frame(8'h33, 1'b0, 1'b0);
    chk("stop_err_seen", err_q.size(), 0);
    chk("stop_err_ready", rx_data_ready, 0);
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    chk("pre_reset_ready", rx_data_ready, 1);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    cyc(3);
    chk("mid_rst_code", rx_scan_code, 0);
    chk("mid_rst_ready", rx_data_ready, 0);
    chk("mid_rst_ovf", rx_overflow, 0);
    chk("mid_rst_errs", {rx_parity_err, rx_frame_err}, 0);
    ps2_data_i = 1'b1;
    reset = 1'b0;
    cyc(TO + 100);
    chk("post_rst_ready", rx_data_ready, 0);
    good(8'h66);
    chk("post_rst_frame", rx_data_ready, 1);
    do_read();
    cyc(10);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
